// File: rtl/step_pkg.sv
// Shared constants for the step/run pulse controller.
// State encoding, synchroniser depth and step counter width.
package step_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HELD   = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  localparam int SYNC_STAGES  = 2;
  localparam int STEP_COUNT_W = 16;

endpackage

// File: rtl/debounce_filter.sv
// Synchroniser plus stable-count debouncer for a raw pushbutton.
// Ports: clk, rst (sync, active-high), raw (async in), level (debounced, resets to 1).
module debounce_filter
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // level starts high so a button held through reset never
  // looks like a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      if (synced == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q <= '0;
        level <= ~level;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Single-step / free-run clock-enable generator for the CPU core.
// Ports: clk, rst, next_instr, run_mode, halt in; step_en, state, step_count out.
// Optional step counter built only when STEP_COUNT_EN is defined.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    next_instr,
  input  logic                    run_mode,
  input  logic                    halt,
  output logic                    step_en,
  output logic [1:0]              state,
  output logic [STEP_COUNT_W-1:0] step_count
);

  localparam int DW = $clog2(RUN_DIV);

  logic                   db_level;
  logic [SYNC_STAGES-1:0] run_q;
  logic                   run_sync;
  logic [1:0]             state_q;
  logic [DW-1:0]          div_q;

  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (next_instr),
    .level(db_level)
  );

  // The switch is only synchronised; a bouncing switch just
  // toggles RUN a few times before settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
    end else begin
      run_q <= {run_q[SYNC_STAGES-2:0], run_mode};
    end
  end

  assign run_sync = run_q[SYNC_STAGES-1];

  // halt is checked before any pulse source so a halting
  // CPU never receives one more advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HELD;
      step_en <= 1'b0;
      div_q   <= '0;
    end else begin
      step_en <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!halt) begin
            if (run_sync) begin
              state_q <= RUN;
              div_q   <= '0;
            end else if (db_level) begin
              step_en <= 1'b1;
              state_q <= HELD;
            end
          end
        end
        HELD: begin
          if (!db_level) state_q <= IDLE;
        end
        RUN: begin
          if (halt) begin
            state_q <= HALTED;
            div_q   <= '0;
          end else if (!run_sync) begin
            state_q <= db_level ? HELD : IDLE;
            div_q   <= '0;
          end else if (div_q == DW'(RUN_DIV - 1)) begin
            div_q   <= '0;
            step_en <= 1'b1;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        HALTED: begin
          if (!halt && !run_sync) state_q <= IDLE;
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef STEP_COUNT_EN
  logic [STEP_COUNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (step_en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign step_count = count_q;
`else
  assign step_count = '0;
`endif

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Single-step and free-run controller that sits directly upstream of the CPU core.
- Takes the raw next-instruction pushbutton and a run/step slide switch, and produces a clean one-cycle step_en pulse for the CPU's clock-enable.
- Provides debounce, one pulse per press, a divided free-run rate, and a stop on CPU halt.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before the debounced button level changes (10 ms at 50 MHz). Must be ≥1.
- RUN_DIV, 25000000: clock cycles between step pulses in RUN state. Must be ≥2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- next_instr  input  1  raw pushbutton, asynchronous, active-high, bouncy
- run_mode  input  1  raw slide switch, asynchronous; 1 = free-run, 0 = single-step
- halt  input  1  CPU halted flag, synchronous to clk, active-high
- step_en  output  1  one-cycle CPU advance pulse, registered
- state  output  2  current FSM state, for debug LEDs
- step_count  output  16  number of step_en pulses issued (see Optional Feature)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Synchronisers: next_instr and run_mode each pass through a 2-FF synchroniser. Both flops reset to 0.
- Debounce (next_instr only):
  - db_level resets to 1.
  - A counter increments on every edge where the synced value differs from db_level, and clears when they match.
  - db_level flips on the DEBOUNCE_CYCLES-th consecutive differing edge; the counter then clears.
  - Net latency: a raw change first sampled at edge 1 moves db_level at edge DEBOUNCE_CYCLES+2.
- run_mode is synchronised only, not debounced.
- FSM state encoding: IDLE=0, HELD=1, RUN=2, HALTED=3. Reset state is HELD.
  - Because db_level and the FSM reset to 1/HELD, a button held through reset never produces a step.
- IDLE:
  - If halt=1: stay, no pulse.
  - Else if run_sync=1: go to RUN and clear the divider.
  - Else if db_level=1: assert step_en for exactly one cycle (the edge after db_level rose) and go to HELD.
- HELD:
  - No pulses.
  - Go to IDLE when db_level=0.
  - run_sync is ignored until release.
- RUN:
  - Divider counts 0..RUN_DIV-1 and wraps.
  - step_en=1 for one cycle when the divider wraps, i.e. the first pulse comes RUN_DIV cycles after entry, then one every RUN_DIV cycles.
  - If halt=1: go to HALTED.
  - Else if run_sync=0: go to HELD if db_level=1, otherwise IDLE; clear the divider.
  - The button is ignored in RUN.
- HALTED:
  - No pulses.
  - Go to IDLE when halt=0 and run_sync=0.
  - Remains HALTED while run_sync=1, even if halt drops.
- Simultaneous events:
  - halt=1 on the same edge as the divider wrap or a debounced press: halt wins and no pulse is issued.
  - run_sync rising on the same edge as a press in IDLE: RUN wins and no single-step pulse is issued.
- step_en is never high on two consecutive cycles.
- Reset values:
  - step_en=0, state=HELD(1), step_count=0.
  - Divider=0, debounce counter=0.
- Reset mid-pulse or mid-RUN: reset has priority on that edge; all reset values apply.

Optional Feature:
- Macro: STEP_COUNT_EN.
- Defined: step_count increments on every cycle where step_en=1, wraps 0xFFFF→0x0000, and is cleared by rst.
- Undefined: step_count is tied to 16'h0000 and no counter flops are built.

Decomposition:
- Package step_pkg holds:
  - the state encoding constants (IDLE, HELD, RUN, HALTED, 2 bits);
  - SYNC_STAGES=2;
  - STEP_COUNT_W=16.
- One natural sub-module, debounce_filter: the synchroniser plus stable-count logic. Parameter DEBOUNCE_CYCLES; ports clk, rst, raw in, level out (resets to 1).
- The FSM, divider and counter stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=5, STEP_COUNT_EN defined):
1. Hold next_instr=1 through reset, release at cycle 10, never re-press → state=HELD after reset, step_en stays 0, state=IDLE by cycle 17.
2. From IDLE, raise next_instr and first sample it at edge 1, holding it high → step_en=1 only between edges 7 and 8, state=HELD, step_count=1.
3. Bounce: next_instr high for 3 cycles, low 1, high 2, then low → no step_en, state stays IDLE.
4. run_mode=1 for 22 cycles after sync → pulses at the 5th, 10th, 15th and 20th edges after RUN entry; step_count=4. Then drop run_mode → IDLE, no further pulses.
5. In RUN, assert halt on the divider-wrap edge → no pulse, state=HALTED. Drop halt with run_mode=1 → still HALTED. Drop run_mode → IDLE.
6. Force step_count to 0xFFFF (65535 run pulses or a bench preload via small divider), issue one more step → step_count=0x0000. Then assert rst mid-RUN → step_en=0, state=1, step_count=0 on the next edge.
